// File: rtl/ctrl_pkg.sv
// Shared types for the control sequencer: instruction classes, FSM states and the
// registered control bundle.
package ctrl_pkg;

  localparam int unsigned AluOpW = 3;

  typedef enum logic [1:0] {
    TypeAlu    = 2'b00,
    TypeBranch = 2'b01,
    TypeImm    = 2'b10,
    TypeMem    = 2'b11
  } instr_type_e;

  typedef enum logic [1:0] {
    StIssue   = 2'b00,
    StMemWait = 2'b01,
    StBubble  = 2'b10
  } seq_state_e;

  typedef struct packed {
    logic              branch;
    logic              write_reg;
    logic              mem_to_reg;
    logic              mem_read;
    logic              mem_write;
    logic              use_immediate;
    logic [AluOpW-1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Fetch-side handshake plus the registered control bundle seen by execute/memory.
interface control_sequencer_if #(
  parameter int unsigned INSTR_W  = 9,
  parameter int unsigned ALU_OP_W = 3,
  parameter int unsigned COUNT_W  = 16
) ();

  logic                instr_valid;
  logic [INSTR_W-1:0]  instr;
  logic                instr_ready;
  logic                flush;
  logic                mem_done;
  logic                ctrl_valid;
  logic                branch;
  logic                write_reg;
  logic                mem_to_reg;
  logic                mem_read;
  logic                mem_write;
  logic                use_immediate;
  logic [ALU_OP_W-1:0] alu_op;
  logic                mem_err;
  logic                busy;
  logic [COUNT_W-1:0]  issued_count;

  modport master (
    output instr_valid, instr, flush, mem_done,
    input  instr_ready, ctrl_valid, branch, write_reg, mem_to_reg, mem_read, mem_write,
           use_immediate, alu_op, mem_err, busy, issued_count
  );

  modport slave (
    input  instr_valid, instr, flush, mem_done,
    output instr_ready, ctrl_valid, branch, write_reg, mem_to_reg, mem_read, mem_write,
           use_immediate, alu_op, mem_err, busy, issued_count
  );

endinterface

// File: rtl/ctrl_decode_comb.sv
// Purely combinational instruction -> control bundle mapping.
module ctrl_decode_comb
  import ctrl_pkg::*;
#(
  parameter int unsigned INSTR_W = 9
) (
  input  logic [INSTR_W-1:0] instr,
  output ctrl_t              ctrl
);

  instr_type_e itype;
  logic        rw;

  assign itype = instr_type_e'(instr[INSTR_W-1 -: 2]);
  assign rw    = instr[INSTR_W-3];

  always_comb begin
    ctrl = '0;
    unique case (itype)
      TypeAlu: begin
        ctrl.alu_op    = AluOpW'(1);
        ctrl.write_reg = 1'b1;
      end
      TypeBranch: begin
        ctrl.alu_op = AluOpW'(1);
        ctrl.branch = 1'b1;
      end
      TypeImm: begin
        ctrl.alu_op        = AluOpW'(1);
        ctrl.write_reg     = 1'b1;
        ctrl.use_immediate = 1'b1;
      end
      TypeMem: begin
        if (rw) begin
          ctrl.mem_write = 1'b1;
        end else begin
          ctrl.mem_read   = 1'b1;
          ctrl.write_reg  = 1'b1;
          ctrl.mem_to_reg = 1'b1;
        end
      end
      default: ctrl = '0;
    endcase
  end

  // Operand bits below the class/rw fields do not affect control.
  if (INSTR_W > 3) begin : g_unused
    logic unused_operand;
    assign unused_operand = ^instr[INSTR_W-4:0];
  end

endmodule

// File: rtl/control_sequencer.sv
// Registered control sequencer: decodes accepted instructions one cycle later, holds memory
// ops until completion or timeout, and stalls fetch for a fixed bubble after each branch.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned INSTR_W        = 9,
  parameter int unsigned ALU_OP_W       = 3,
  parameter int unsigned BRANCH_BUBBLES = 2,
  parameter int unsigned MEM_TIMEOUT    = 4,
  parameter int unsigned COUNT_W        = 16
) (
  input logic                clk,
  input logic                rst_n,
  control_sequencer_if.slave bus
);

  localparam int unsigned TmoW = $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned BubW = (BRANCH_BUBBLES > 0) ? $clog2(BRANCH_BUBBLES + 1) : 1;

  seq_state_e         state_q;
  ctrl_t              ctrl_q;
  ctrl_t              dec;
  logic               ctrl_valid_q;
  logic               mem_err_q;
  logic [TmoW-1:0]    tmo_q;
  logic [BubW-1:0]    bub_q;
  logic [COUNT_W-1:0] issued_q;
  logic               ready;
  logic               accept;
  logic               dec_is_mem;

  ctrl_decode_comb #(
    .INSTR_W (INSTR_W)
  ) u_decode (
    .instr (bus.instr),
    .ctrl  (dec)
  );

  assign ready      = (state_q == StIssue) && !bus.flush;
  assign accept     = bus.instr_valid && ready;
  assign dec_is_mem = dec.mem_read || dec.mem_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIssue;
      ctrl_q       <= '0;
      ctrl_valid_q <= 1'b0;
      mem_err_q    <= 1'b0;
      tmo_q        <= '0;
      bub_q        <= '0;
      issued_q     <= '0;
    end else begin
      mem_err_q <= 1'b0;
      if (bus.flush) begin
        state_q      <= StIssue;
        ctrl_q       <= '0;
        ctrl_valid_q <= 1'b0;
        tmo_q        <= '0;
        bub_q        <= '0;
      end else begin
        unique case (state_q)
          StIssue: begin
            if (accept) begin
              ctrl_q       <= dec;
              ctrl_valid_q <= 1'b1;
              issued_q     <= issued_q + COUNT_W'(1);
              if (dec_is_mem) begin
                state_q <= StMemWait;
                tmo_q   <= '0;
              end else if (dec.branch && (BRANCH_BUBBLES > 0)) begin
                state_q <= StBubble;
                bub_q   <= BubW'(BRANCH_BUBBLES);
              end
            end else begin
              ctrl_q       <= '0;
              ctrl_valid_q <= 1'b0;
            end
          end
          StMemWait: begin
            // Completion beats a coincident timeout, so mem_err only fires without mem_done.
            if (bus.mem_done || (tmo_q == TmoW'(MEM_TIMEOUT - 1))) begin
              state_q      <= StIssue;
              ctrl_q       <= '0;
              ctrl_valid_q <= 1'b0;
              tmo_q        <= '0;
              mem_err_q    <= !bus.mem_done;
            end else begin
              tmo_q <= tmo_q + TmoW'(1);
            end
          end
          StBubble: begin
            ctrl_q       <= '0;
            ctrl_valid_q <= 1'b0;
            if (bub_q <= BubW'(1)) begin
              state_q <= StIssue;
              bub_q   <= '0;
            end else begin
              bub_q <= bub_q - BubW'(1);
            end
          end
          default: begin
            state_q      <= StIssue;
            ctrl_q       <= '0;
            ctrl_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.instr_ready   = ready;
  assign bus.busy          = (state_q != StIssue);
  assign bus.ctrl_valid    = ctrl_valid_q;
  assign bus.branch        = ctrl_q.branch;
  assign bus.write_reg     = ctrl_q.write_reg;
  assign bus.mem_to_reg    = ctrl_q.mem_to_reg;
  assign bus.mem_read      = ctrl_q.mem_read;
  assign bus.mem_write     = ctrl_q.mem_write;
  assign bus.use_immediate = ctrl_q.use_immediate;
  assign bus.alu_op        = ALU_OP_W'(ctrl_q.alu_op);
  assign bus.mem_err       = mem_err_q;
  assign bus.issued_count  = issued_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomised scoreboard bench for control_sequencer with directed branch, memory, flush and
// reset scenarios.
module tb_control_sequencer;

  localparam int BB = 2;
  localparam int MT = 4;

  typedef struct {
    logic [8:0]  bundle;
    int          hold;
    bit          err;
    bit          busy;
    logic [15:0] count;
  } item_t;

  logic clk = 1'b0;
  logic rst_n;

  control_sequencer_if #(.INSTR_W(9), .ALU_OP_W(3), .COUNT_W(16)) bus ();

  control_sequencer #(
    .INSTR_W        (9),
    .ALU_OP_W       (3),
    .BRANCH_BUBBLES (BB),
    .MEM_TIMEOUT    (MT),
    .COUNT_W        (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  item_t       sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          next_free = 0;
  int          done_cycle = -1;
  bit          mem_pending = 0;
  bit          suppress_done = 0;
  int unsigned acc_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // {branch, write_reg, mem_to_reg, mem_read, mem_write, use_immediate, alu_op[2:0]}
  function automatic logic [8:0] exp_decode(input logic [8:0] ins);
    case (ins[8:7])
      2'b00:   return {6'b010000, 3'd1};
      2'b01:   return {6'b100000, 3'd1};
      2'b10:   return {6'b010001, 3'd1};
      default: return ins[6] ? {6'b000010, 3'd0} : {6'b011100, 3'd0};
    endcase
  endfunction

  function automatic logic [8:0] act_vec();
    return {bus.branch, bus.write_reg, bus.mem_to_reg, bus.mem_read, bus.mem_write,
            bus.use_immediate, bus.alu_op};
  endfunction

  task automatic rand_inputs();
    bus.instr_valid = 1'($urandom);
    bus.instr       = 9'($urandom);
    bus.flush       = 1'($urandom);
    bus.mem_done    = 1'($urandom);
  endtask

  // One fetch cycle: drive inputs, check instr_ready against the model, record accepts.
  // k is the cycle (relative to accept) at which mem_done is raised for a memory op.
  task automatic step(input bit v, input logic [8:0] ins, input int k, input bit fl);
    bit exp_ready;
    @(posedge clk);
    #1;
    cyc++;
    exp_ready = (cyc >= next_free) && !fl;
    if (mem_pending && cyc < next_free) bus.mem_done = !suppress_done && (cyc == done_cycle);
    else bus.mem_done = 1'($urandom);
    bus.flush       = fl;
    bus.instr_valid = v;
    bus.instr       = ins;
    #1;
    check("instr_ready", 32'(bus.instr_ready), 32'(exp_ready));
    if (v && exp_ready) begin
      item_t it;
      acc_count++;
      it.bundle = exp_decode(ins);
      it.count  = 16'(acc_count);
      it.hold   = 1;
      it.err    = 1'b0;
      it.busy   = 1'b0;
      if (ins[8:7] == 2'b11) begin
        it.hold     = (k < MT) ? k : MT;
        it.err      = (k > MT);
        it.busy     = 1'b1;
        mem_pending = 1'b1;
        done_cycle  = cyc + k;
        next_free   = cyc + it.hold + 1;
      end else if (ins[8:7] == 2'b01) begin
        it.busy   = (BB > 0);
        next_free = cyc + BB + 1;
      end else begin
        next_free = cyc + 1;
      end
      sb.push_back(it);
    end
    if (fl) begin
      next_free     = cyc + 1;
      mem_pending   = 1'b0;
      suppress_done = 1'b0;
    end
  endtask

  task automatic wait_ready();
    while (cyc + 1 < next_free) step(1'b0, 9'd0, 1, 1'b0);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b0;
    rand_inputs();
    #1;
    check("rst_async_busy", 32'(bus.busy), 32'd0);
    check("rst_async_outs", 32'({bus.ctrl_valid, act_vec(), bus.mem_err}), 32'd0);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      rand_inputs();
    end
    @(posedge clk);
    #1;
    cyc++;
    rst_n           = 1'b1;
    bus.flush       = 1'b0;
    bus.instr_valid = 1'b0;
    bus.mem_done    = 1'b0;
    #1;
    check("ready_after_rst", 32'(bus.instr_ready), 32'd1);
    next_free     = cyc;
    mem_pending   = 1'b0;
    suppress_done = 1'b0;
    acc_count     = 0;
  endtask

  // Monitor: pops an expected bundle whenever ctrl_valid rises and tracks its hold time.
  initial begin : monitor
    item_t       cur;
    int          rem = 0;
    bit          exp_err = 0;
    logic [15:0] last_count = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("reset_outs", 32'({bus.ctrl_valid, act_vec(), bus.mem_err, bus.busy}), 32'd0);
        check("reset_count", 32'(bus.issued_count), 32'd0);
        sb.delete();
        rem        = 0;
        exp_err    = 0;
        last_count = '0;
      end else begin
        check("mem_err", 32'(bus.mem_err), 32'(exp_err));
        exp_err = 0;
        if (rem == 0 && bus.ctrl_valid) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ctrl_valid: got bundle %0h expected none at t=%0t",
                     act_vec(), $time);
          end else begin
            cur = sb.pop_front();
            rem = cur.hold;
            check("issued_count", 32'(bus.issued_count), 32'(cur.count));
            last_count = cur.count;
          end
        end
        if (rem > 0) begin
          check("ctrl_valid", 32'(bus.ctrl_valid), 32'd1);
          check("bundle", 32'(act_vec()), 32'(cur.bundle));
          check("busy", 32'(bus.busy), 32'(cur.busy));
          rem--;
          if (rem == 0) exp_err = cur.err;
        end else begin
          check("idle_zero", 32'({bus.ctrl_valid, act_vec()}), 32'd0);
          check("idle_count", 32'(bus.issued_count), 32'(last_count));
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish expected finish by t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst_n           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.flush       = 1'b0;
    bus.mem_done    = 1'b0;
    do_reset(3);

    // Back-to-back ALU then immediate.
    wait_ready();
    step(1'b1, 9'b000000101, 1, 1'b0);
    step(1'b1, 9'b100110011, 1, 1'b0);

    // Branch: two cycles of stall, offered instructions are refused until t+3.
    wait_ready();
    step(1'b1, 9'b010000000, 1, 1'b0);
    step(1'b1, 9'b000000001, 1, 1'b0);
    step(1'b1, 9'b000000001, 1, 1'b0);
    step(1'b1, 9'b100000010, 1, 1'b0);

    // Load with late completion, store timeout, store with coincident completion.
    wait_ready();
    step(1'b1, 9'b110000001, 3, 1'b0);
    wait_ready();
    step(1'b1, 9'b111000000, 6, 1'b0);
    wait_ready();
    step(1'b1, 9'b111000000, 4, 1'b0);

    // Flush on the second memory-wait cycle with no completion.
    wait_ready();
    suppress_done = 1'b1;
    step(1'b1, 9'b110000001, 2, 1'b0);
    step(1'b0, 9'd0, 1, 1'b0);
    step(1'b1, 9'b000000011, 1, 1'b1);
    step(1'b0, 9'd0, 1, 1'b0);
    step(1'b0, 9'd0, 1, 1'b0);

    repeat (400) step($urandom_range(0, 3) != 0, 9'($urandom), $urandom_range(1, 6), 1'b0);

    // Reset while holding a store, then while in a branch bubble.
    wait_ready();
    step(1'b1, 9'b111000000, 6, 1'b0);
    step(1'b0, 9'd0, 1, 1'b0);
    do_reset(2);
    wait_ready();
    step(1'b1, 9'b010000000, 1, 1'b0);
    step(1'b0, 9'd0, 1, 1'b0);
    do_reset(2);

    repeat (60) step($urandom_range(0, 3) != 0, 9'($urandom), $urandom_range(1, 6), 1'b0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) step(1'b0, 9'd0, 1, 1'b0);
    step(1'b0, 9'd0, 1, 1'b0);
    step(1'b0, 9'd0, 1, 1'b0);
    check("drain", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
